// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: branch opcodes, the NOP encoding, the ID-stage
// branch state and the decoded-branch payload used by the redirect logic.
package pipe_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned INSTR_W = 16;

  localparam logic [OP_W-1:0] OP_BEQZ = 4'hC;
  localparam logic [OP_W-1:0] OP_BNEZ = 4'hD;
  localparam logic [OP_W-1:0] OP_JMP  = 4'hE;
  localparam logic [OP_W-1:0] OP_JR   = 4'hF;

  localparam logic [INSTR_W-1:0] NOP = 16'h0000;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT    = 2'd1,
    RESOLVE = 2'd2
  } state_e;

  // One-hot view of the branch class held in IF/ID
  typedef struct packed {
    logic jmp;
    logic beqz;
    logic bnez;
    logic jr;
  } br_dec_t;

  function automatic br_dec_t decode_op(input logic [OP_W-1:0] op);
    br_dec_t d;
    d      = '0;
    d.jmp  = (op == OP_JMP);
    d.beqz = (op == OP_BEQZ);
    d.bnez = (op == OP_BNEZ);
    d.jr   = (op == OP_JR);
    return d;
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Branch target generator: PC+1 plus sign-extended offset, or the register
// operand for JR. Purely combinational.
//   op          in  opcode field of the ID instruction
//   off         in  signed branch offset field
//   pc_plus_one in  PC+1 of the ID instruction
//   opnd        in  captured register operand
//   target      out redirect target (sum wraps mod 2^DW)
module branch_target_calc
  import pipe_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned OFF_W = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [OFF_W-1:0] off,
  input  logic [DW-1:0]    pc_plus_one,
  input  logic [DW-1:0]    opnd,
  output logic [DW-1:0]    target
);

  logic [DW-1:0] off_sext;

  assign off_sext = {{(DW-OFF_W){off[OFF_W-1]}}, off};
  assign target   = (op == OP_JR) ? opnd : pc_plus_one + off_sext;

endmodule

// File: rtl/id_branch_redirect.sv
// ID-stage branch resolver. Owns the IF/ID register, decodes JMP/BEQZ/BNEZ/JR,
// and drives the redirect target and PC select back to the IF next-PC mux.
// A taken redirect squashes the wrong-path fetch into a bubble; conditional
// branches and JR hold IF until their register operand is captured.
// Optional feature macro: BRANCH_STATS_EN adds saturating redirect_cnt and
// fallthru_cnt outputs.
//   if_pc_plus_one/if_instr/if_valid  in  fetch-side instruction
//   ex_stall                          in  downstream stall, freezes ID
//   rs_data/rs_ready                  in  regfile operand and its readiness
//   id_instr/id_pc_plus_one/id_valid  out IF/ID register
//   id_pc/pc_sel/if_hold              out combinational redirect controls to IF
module id_branch_redirect
  import pipe_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned OFF_W = 8
`ifdef BRANCH_STATS_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] if_pc_plus_one,
  input  logic [DW-1:0] if_instr,
  input  logic          if_valid,
  input  logic          ex_stall,
  input  logic [DW-1:0] rs_data,
  input  logic          rs_ready,
  output logic [DW-1:0] id_instr,
  output logic [DW-1:0] id_pc_plus_one,
  output logic          id_valid,
  output logic [DW-1:0] id_pc,
  output logic          pc_sel,
  output logic          if_hold
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] fallthru_cnt
`endif
);

  state_e        state_q, state_d;
  logic [DW-1:0] opnd_q, opnd_d;
  br_dec_t       dec;
  logic          resolve_taken;

  // Only a valid IF/ID entry may be treated as a branch
  assign dec = id_valid ? decode_op(id_instr[DW-1 -: OP_W]) : '0;

  assign resolve_taken = dec.jr
                       | (dec.beqz & (opnd_q == '0))
                       | (dec.bnez & (opnd_q != '0));

  branch_target_calc #(
    .DW    (DW),
    .OFF_W (OFF_W)
  ) u_target (
    .op          (id_instr[DW-1 -: OP_W]),
    .off         (id_instr[OFF_W-1:0]),
    .pc_plus_one (id_pc_plus_one),
    .opnd        (opnd_q),
    .target      (id_pc)
  );

  // State and operand register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
    end
  end

  // Next state and redirect controls; ex_stall freezes everything
  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    pc_sel  = 1'b0;
    if_hold = 1'b0;
    if (ex_stall) begin
      if_hold = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (dec.jmp) begin
            pc_sel = 1'b1;
          end else if (dec.beqz | dec.bnez | dec.jr) begin
            if_hold = 1'b1;
            if (rs_ready) begin
              opnd_d  = rs_data;
              state_d = RESOLVE;
            end else begin
              state_d = WAIT;
            end
          end
        end
        WAIT: begin
          if_hold = 1'b1;
          if (rs_ready) begin
            opnd_d  = rs_data;
            state_d = RESOLVE;
          end
        end
        RESOLVE: begin
          pc_sel  = resolve_taken;
          state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // IF/ID register; a taken redirect loads a bubble in place of the wrong path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_instr       <= DW'(NOP);
      id_pc_plus_one <= '0;
      id_valid       <= 1'b0;
    end else if (!ex_stall && !if_hold) begin
      id_pc_plus_one <= if_pc_plus_one;
      if (pc_sel) begin
        id_instr <= DW'(NOP);
        id_valid <= 1'b0;
      end else begin
        id_instr <= if_valid ? if_instr : DW'(NOP);
        id_valid <= if_valid;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  logic fallthru_c;

  assign fallthru_c = (state_q == RESOLVE) && !ex_stall && !resolve_taken;

  // Saturating taken / not-taken resolution counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt <= '0;
      fallthru_cnt <= '0;
    end else begin
      if (pc_sel && (redirect_cnt != '1)) redirect_cnt <= redirect_cnt + CNT_W'(1);
      if (fallthru_c && (fallthru_cnt != '1)) fallthru_cnt <= fallthru_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
